// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and sizes.
// Loader FSM states plus the length-header and word-counter widths.
package imem_loader_pkg;

  localparam int IM_AW_DEF = 10;
  localparam int LEN_W     = 16;
  localparam int CNT_W     = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in and instruction-memory write port out.
// slave = the loader, master = the environment driving it.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int IM_AW = IM_AW_DEF
);

  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             im_we;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output im_we,
    output im_addr,
    output im_wdata
  );

endinterface

// File: rtl/imem_loader_word_pack.sv
// Big-endian byte-to-word packer for the loader.
// word/word_ready are valid in the cycle the 4th byte is accepted.
module imem_loader_word_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  idx;
  logic [23:0] sr;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      idx <= 2'd0;
      sr  <= 24'd0;
    end else if (en) begin
      idx <= idx + 2'd1;
      sr  <= {sr[15:0], data};
    end
  end

  assign word       = {sr, data};
  assign word_ready = en && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed image into the IM,
// holding the CPU in reset until the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IM_AW = IM_AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** IM_AW);

  state_t           state;
  logic [7:0]       len_hi;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] wcnt_nxt;
  logic [LEN_W-1:0] len;
  logic             xfer;
  logic [31:0]      word;
  logic             word_ready;

  assign xfer     = bus.rx_valid && bus.rx_ready;
  assign len      = {len_hi, bus.rx_data};
  assign wcnt_nxt = wcnt + CNT_W'(1);

  imem_loader_word_pack u_pack (
    .clk        (clk),
    .reset      (reset),
    .clr        (state != S_DATA),
    .en         (xfer && (state == S_DATA)),
    .data       (bus.rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      bus.rx_ready <= 1'b0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      len_hi       <= 8'd0;
      n_words      <= '0;
      wcnt         <= '0;
    end else begin
      bus.im_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_LEN_HI;
            bus.rx_ready <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= bus.rx_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            n_words     <= CNT_W'(len);
            wcnt        <= '0;
            bus.im_addr <= '0;
            if (len == '0) begin
              state        <= S_DONE;
              bus.rx_ready <= 1'b0;
              done         <= 1'b1;
              cpu_hold     <= 1'b0;
            end else if (CNT_W'(len) > MAX_WORDS) begin
              state        <= S_ERR;
              bus.rx_ready <= 1'b0;
              err          <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_ready) begin
            state        <= S_WRITE;
            bus.rx_ready <= 1'b0;
            bus.im_we    <= 1'b1;
            bus.im_wdata <= word;
          end
        end
        S_WRITE: begin
          // address may roll over only on the final write, as we leave
          bus.im_addr <= bus.im_addr + 1'b1;
          wcnt        <= wcnt_nxt;
          if (wcnt_nxt == n_words) begin
            state    <= S_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state        <= S_DATA;
            bus.rx_ready <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN_HI;
            bus.rx_ready <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_hold     <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader against a queue-based
// model of the length-prefixed image format.
module tb_imem_loader;

  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  imem_loader_if #(.IM_AW(AW)) bus ();

  imem_loader #(.IM_AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs = 0;

  logic [7:0]  pay [$];
  logic [31:0] obs_addr [$];
  logic [31:0] obs_data [$];
  logic [31:0] dut_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          rdy_in_wr = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // write-port monitor
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      obs_addr.push_back(32'(bus.im_addr));
      obs_data.push_back(bus.im_wdata);
      dut_mem[bus.im_addr] = bus.im_wdata;
      if (bus.rx_ready !== 1'b0) rdy_in_wr++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // gap: 0 none, 1 one idle cycle per byte, 2 random idles + stray start
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      if (gap == 2) start = 1'($urandom_range(0, 1));
      repeat (gap == 1 ? 1 : $urandom_range(1, 3)) @(posedge clk);
      #1;
      start = 1'b0;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.rx_ready !== 1'b1 && t < 100);
    if (t >= 100) check("rx_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_load(input int n, input int gap);
    logic [15:0] len;
    bit          ok;
    bit          good;
    int          t;
    int          nw;
    logic [31:0] w;
    len  = 16'(n);
    ok   = (n >= 1 && n <= DEPTH);
    good = ok || n == 0;
    obs_addr.delete();
    obs_data.delete();
    rdy_in_wr = 0;
    pulse_start();
    check("busy_after_start", {done, err}, 2'b00);
    send_byte(len[15:8], gap);
    send_byte(len[7:0], gap);
    if (!ok) begin
      check("hdr_done", done, n == 0);
      check("hdr_err", err, n != 0);
    end
    if (ok) for (int i = 0; i < 4 * n; i++) send_byte(pay[i], gap);
    t = 0;
    while (!done && !err && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("done", done, good);
    check("err", err, !good);
    check("cpu_hold", cpu_hold, !good);
    check("rx_ready_end", bus.rx_ready, 0);
    check("rx_ready_in_write", rdy_in_wr, 0);
    nw = ok ? n : 0;
    check("n_writes", obs_addr.size(), nw);
    for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
      w = {pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]};
      ref_mem[i] = w;
      check("wr_addr", obs_addr[i], i);
      check("wr_data", obs_data[i], w);
    end
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_im_we", bus.im_we, 0);
    check("rst_im_addr", bus.im_addr, 0);
    check("rst_im_wdata", bus.im_wdata, 0);
    check("rst_done_err", {done, err}, 2'b00);

    pay = '{8'h3C, 8'h01, 8'h10, 8'h01, 8'hAC, 8'h22, 8'h00, 8'h04};
    do_load(2, 0);
    check("ex_word0", dut_mem[0], 32'h3C011001);
    check("ex_word1", dut_mem[1], 32'hAC220004);

    do_load(0, 0);
    do_load(16'h0401, 0);

    rand_pay(1);
    do_load(1, 1);

    // reset mid-load, also colliding with start and a valid byte
    pay = '{8'h11, 8'h22};
    obs_addr.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(pay[0], 0);
    send_byte(pay[1], 0);
    reset = 1'b0;
    start = 1'b1;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    check("mid_rst_rx_ready", bus.rx_ready, 0);
    check("mid_rst_cpu_hold", cpu_hold, 1);
    check("mid_rst_im_we", bus.im_we, 0);
    check("mid_rst_addr", bus.im_addr, 0);
    check("mid_rst_wdata", bus.im_wdata, 0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_write", obs_addr.size(), 0);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_load(1, 2);
    check("reload_word", dut_mem[0], 32'hDEADBEEF);

    for (int k = 0; k < 10; k++) begin
      int n;
      n = $urandom_range(1, 8);
      rand_pay(n);
      do_load(n, 2);
    end
    do_load($urandom_range(DEPTH + 1, 65535), 2);

    pay.delete();
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] a;
      a = 32'(i);
      pay.push_back(a[31:24]);
      pay.push_back(a[23:16]);
      pay.push_back(a[15:8]);
      pay.push_back(a[7:0]);
    end
    do_load(DEPTH, 0);
    check("last_addr", obs_addr[obs_addr.size()-1], DEPTH - 1);
    check("last_data", obs_data[obs_data.size()-1], 32'h000003FF);
    rand_pay(1);
    do_load(1, 0);
    check("ovw_mem0", dut_mem[0], ref_mem[0]);
    check("ovw_mem1", dut_mem[1], 32'h00000001);
    check("ovw_mem_last", dut_mem[DEPTH-1], 32'h000003FF);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter IM_AW, default 10, the instruction-memory word-address width (1024 words).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low; clears all state on the clk edge where it is 0.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-005 SHALL have port rx_valid  input  1  byte stream valid.
REQ-006 SHALL have port rx_data  input  8  byte stream data.
REQ-007 SHALL have port rx_ready  output  1  byte stream ready; a byte transfers on an edge where rx_valid and rx_ready are both 1.
REQ-008 SHALL have port im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port im_addr  output  IM_AW  instruction-memory word address.
REQ-010 SHALL have port im_wdata  output  32  instruction word to write.
REQ-011 SHALL have port cpu_hold  output  1  1 holds the CPU in reset; 0 lets it run from PC 0.
REQ-012 SHALL have port done  output  1  load completed successfully; level.
REQ-013 SHALL have port err  output  1  load rejected; level.

Function
REQ-014 SHALL use states IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
REQ-015 IDLE: cpu_hold=1, rx_ready=0; start=1 -> LEN_HI.
REQ-016 LEN_HI/LEN_LO: rx_ready=1; accept a 16-bit big-endian word count N, high byte first.
REQ-017 After LEN_LO: N=0 -> DONE; N>2**IM_AW -> ERR; otherwise -> DATA with word address 0 and byte count 0.
REQ-018 DATA: rx_ready=1; pack bytes big-endian (first byte -> bits 31:24); the 4th accepted byte -> WRITE.
REQ-019 WRITE: exactly one cycle, on the edge after the 4th byte; im_we=1, im_wdata=packed word, im_addr=current word address, rx_ready=0.
REQ-020 After WRITE: increment the word address; if N words are written -> DONE, else -> DATA.
REQ-021 im_we SHALL be 0 in every state except WRITE; im_addr and im_wdata are don't-care when im_we=0.
REQ-022 DONE: done=1, cpu_hold=0, rx_ready=0.
REQ-023 ERR: err=1, cpu_hold=1, rx_ready=0; no memory writes occur for a rejected load.
REQ-024 start=1 in DONE or ERR -> LEN_HI, clearing done and err on the same edge; start in any other state is ignored.
REQ-025 rx_valid=0 in any receiving state: hold the state, packed bytes and counters unchanged; gaps between bytes have no length limit.
REQ-026 N=2**IM_AW: the final write targets address 2**IM_AW-1; the address counter SHALL NOT wrap before DONE.
REQ-027 The word counter SHALL be 17 bits wide so that N up to 65535 compares without overflow.

Reset
REQ-028 reset=0 on a clk edge -> IDLE, with cpu_hold=1, rx_ready=0, im_we=0, im_addr=0, im_wdata=0, done=0, err=0, and all counters 0.
REQ-029 Reset mid-load SHALL discard the partially packed word; no im_we pulse follows the reset edge.
REQ-030 reset SHALL take priority over start and over stream handshakes on the same edge.

Structure
REQ-031 State encodings, IM_AW default and the length-header width SHALL live in shared include file loader_def.v, alongside the existing def files.
REQ-032 Byte-to-word packing MAY be one sub-module, word_pack: 2-bit byte index, 32-bit shift register, word_ready pulse.
REQ-033 Expected RTL size is 150-250 lines; the block contains no memory itself and drives the existing IM through a write port.

Verification
REQ-034 Send N=2 and bytes 3C 01 10 01 AC 22 00 04 -> im_we pulses twice: addr 0 = 0x3C011001, addr 1 = 0xAC220004; then done=1, cpu_hold=0.
REQ-035 Send N=0 (00 00) -> DONE on the edge after LEN_LO, no im_we pulse, done=1.
REQ-036 Send N=0x0401 with IM_AW=10 -> ERR, err=1, cpu_hold=1, zero writes.
REQ-037 Send N=1 with rx_valid toggling 1/0 each cycle -> one write of the correct word; rx_ready=0 in the WRITE cycle; no byte lost or duplicated.
REQ-038 Assert reset=0 after 2 data bytes, then reload N=1 with word 0xDEADBEEF -> a single write, addr 0 = 0xDEADBEEF.
REQ-039 Load N=1024 with data = address -> the last write is addr 1023 with data 0x000003FF; done=1; a later start followed by N=1 overwrites addr 0 only.
